// File: rtl/riscv_zero_decode_pipe_if.sv
// Fetch, writeback and ID/EX signals of the riscv_zero decode stage.
// The decode stage uses the slave modport; its environment uses master.
interface riscv_zero_decode_pipe_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] pc_in;
    logic            flush;
    logic            reg_wenable;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic            id_valid;
    logic            ex_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;
    logic [4:0]      reg_dest;
    logic [XLEN-1:0] reg1_out;
    logic [XLEN-1:0] reg2_out;
    logic [XLEN-1:0] immediate;
    logic [PC_W-1:0] pc_out;
    logic            writeback_enable;
    logic [1:0]      writeback_source;
    logic            mem_wenable;
    logic            mem_renable;
    logic            jump;
    logic            branch;
    logic            ALU_A_mux;
    logic            ALU_B_mux;
    logic            illegal;

    modport master (
        output if_valid, inst_data, pc_in, flush, reg_wenable, reg_waddr, reg_wdata, ex_ready,
        input  if_ready, id_valid, opcode, funct3_out, funct7_out, reg_dest, reg1_out, reg2_out,
               immediate, pc_out, writeback_enable, writeback_source, mem_wenable, mem_renable,
               jump, branch, ALU_A_mux, ALU_B_mux, illegal
    );

    modport slave (
        input  if_valid, inst_data, pc_in, flush, reg_wenable, reg_waddr, reg_wdata, ex_ready,
        output if_ready, id_valid, opcode, funct3_out, funct7_out, reg_dest, reg1_out, reg2_out,
               immediate, pc_out, writeback_enable, writeback_source, mem_wenable, mem_renable,
               jump, branch, ALU_A_mux, ALU_B_mux, illegal
    );
endinterface

// File: rtl/riscv_zero_decode_pipe.sv
// Pipelined RV64I decode stage: register file, decode, ID/EX register with
// load-use stall, flush and optional writeback bypass.

// One register read port: x0 is zero, same-cycle writeback optionally forwarded.
// Also reports whether the writeback hits the operand held in ID/EX.
module riscv_zero_read_port #(
    parameter int XLEN   = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [4:0]      held_addr,
    input  logic            wenable,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            held_hit
);
    logic wb_live;

    assign wb_live  = BYPASS && wenable && (waddr != 5'd0);
    assign held_hit = wb_live && (waddr == held_addr);

    always_comb begin
        rdata = rf_data;
        if (addr == 5'd0)
            rdata = '0;
        else if (wb_live && waddr == addr)
            rdata = wdata;
    end
endmodule

module riscv_zero_decode_pipe #(
    parameter int XLEN   = 64,
    parameter int PC_W   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    riscv_zero_decode_pipe_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
        logic            wb_en;
        logic [1:0]      wb_src;
        logic            mem_we;
        logic            mem_re;
        logic            jump;
        logic            branch;
        logic            a_mux;
        logic            b_mux;
        logic            illegal;
    } id_ex_t;

    logic [31:0][XLEN-1:0] rf;
    id_ex_t                idex_q;
    id_ex_t                dec;
    logic                  id_vld;
    logic [1:0][4:0]       src_addr;
    logic [1:0][4:0]       held_addr;
    logic [1:0][XLEN-1:0]  src_data;
    logic [1:0]            held_hit;
    logic [31:0]           inst;
    logic [6:0]            op;
    logic                  uses_rs2;
    logic                  hazard;
    logic                  accept;

    assign inst = bus.inst_data;
    assign op   = inst[6:0];

    // LUI has no source register, so its rs1 is steered to x0 to force reg1_out to 0
    assign src_addr[0] = (op == OP_LUI) ? 5'd0 : inst[19:15];
    assign src_addr[1] = inst[24:20];

    for (genvar p = 0; p < 2; p++) begin : g_port
        riscv_zero_read_port #(.XLEN(XLEN), .BYPASS(BYPASS)) u_port (
            .addr      (src_addr[p]),
            .rf_data   (rf[src_addr[p]]),
            .held_addr (held_addr[p]),
            .wenable   (bus.reg_wenable),
            .waddr     (bus.reg_waddr),
            .wdata     (bus.reg_wdata),
            .rdata     (src_data[p]),
            .held_hit  (held_hit[p])
        );
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = op;
        dec.funct3  = inst[14:12];
        dec.funct7  = inst[31:25];
        dec.rd      = inst[11:7];
        dec.rs1_val = src_data[0];
        dec.rs2_val = src_data[1];
        dec.pc      = bus.pc_in;
        case (op)
            OP_LUI: begin
                dec.wb_en = 1'b1;
                dec.b_mux = 1'b1;
                dec.imm   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            end
            OP_AUIPC: begin
                dec.wb_en = 1'b1;
                dec.a_mux = 1'b1;
                dec.b_mux = 1'b1;
                dec.imm   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.jump   = 1'b1;
                dec.wb_en  = 1'b1;
                dec.wb_src = 2'd2;
                dec.a_mux  = 1'b1;
                dec.b_mux  = 1'b1;
                dec.imm    = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.jump   = 1'b1;
                dec.wb_en  = 1'b1;
                dec.wb_src = 2'd2;
                dec.b_mux  = 1'b1;
                dec.imm    = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LOAD: begin
                dec.wb_en  = 1'b1;
                dec.wb_src = 2'd1;
                dec.mem_re = 1'b1;
                dec.b_mux  = 1'b1;
                dec.imm    = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                dec.mem_we = 1'b1;
                dec.b_mux  = 1'b1;
                dec.imm    = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_IMM, OP_IMM32: begin
                dec.wb_en = 1'b1;
                dec.b_mux = 1'b1;
                dec.imm   = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_OP, OP_OP32: begin
                dec.wb_en = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign uses_rs2 = (op == OP_OP) || (op == OP_OP32) || (op == OP_STORE) || (op == OP_BRANCH);

    // rs1 is compared for every opcode except LUI; a spurious stall is only a lost cycle
    assign hazard = id_vld && idex_q.mem_re && (idex_q.rd != 5'd0) &&
                    ((src_addr[0] == idex_q.rd) || (uses_rs2 && src_addr[1] == idex_q.rd));

    assign bus.if_ready = bus.flush || ((!id_vld || bus.ex_ready) && !hazard);
    assign accept       = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf        <= '0;
            idex_q    <= '0;
            held_addr <= '0;
            id_vld    <= 1'b0;
        end else begin
            if (bus.reg_wenable && bus.reg_waddr != 5'd0)
                rf[bus.reg_waddr] <= bus.reg_wdata;

            if (bus.flush) begin
                id_vld <= 1'b0;
            end else if (accept) begin
                id_vld    <= 1'b1;
                idex_q    <= dec;
                held_addr <= src_addr;
            end else if (bus.ex_ready) begin
                id_vld <= 1'b0;
            end else if (id_vld) begin
                // stalled: keep held operands coherent with late writebacks
                if (held_hit[0]) idex_q.rs1_val <= bus.reg_wdata;
                if (held_hit[1]) idex_q.rs2_val <= bus.reg_wdata;
            end
        end
    end

    assign bus.id_valid         = id_vld;
    assign bus.opcode           = idex_q.opcode;
    assign bus.funct3_out       = idex_q.funct3;
    assign bus.funct7_out       = idex_q.funct7;
    assign bus.reg_dest         = idex_q.rd;
    assign bus.reg1_out         = idex_q.rs1_val;
    assign bus.reg2_out         = idex_q.rs2_val;
    assign bus.immediate        = idex_q.imm;
    assign bus.pc_out           = idex_q.pc;
    assign bus.writeback_enable = idex_q.wb_en;
    assign bus.writeback_source = idex_q.wb_src;
    assign bus.mem_wenable      = idex_q.mem_we;
    assign bus.mem_renable      = idex_q.mem_re;
    assign bus.jump             = idex_q.jump;
    assign bus.branch           = idex_q.branch;
    assign bus.ALU_A_mux        = idex_q.a_mux;
    assign bus.ALU_B_mux        = idex_q.b_mux;
    assign bus.illegal          = idex_q.illegal;
endmodule

// File: tb/tb_riscv_zero_decode_pipe.sv
// Directed bench for riscv_zero_decode_pipe: a decode vector table plus
// hand sequences for stall, bypass, backpressure, flush and reset.
module tb_riscv_zero_decode_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, flush, reg_wenable, ex_ready;
    logic [31:0] inst_data;
    logic [31:0] pc_in;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    int          n_chk = 0;
    int          n_fail = 0;

    riscv_zero_decode_pipe_if #(.XLEN(64), .PC_W(32)) b1 ();
    riscv_zero_decode_pipe_if #(.XLEN(64), .PC_W(32)) b0 ();

    riscv_zero_decode_pipe #(.XLEN(64), .PC_W(32), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    riscv_zero_decode_pipe #(.XLEN(64), .PC_W(32), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    assign b1.if_valid = if_valid;   assign b0.if_valid = if_valid;
    assign b1.inst_data = inst_data; assign b0.inst_data = inst_data;
    assign b1.pc_in = pc_in;         assign b0.pc_in = pc_in;
    assign b1.flush = flush;         assign b0.flush = flush;
    assign b1.reg_wenable = reg_wenable; assign b0.reg_wenable = reg_wenable;
    assign b1.reg_waddr = reg_waddr; assign b0.reg_waddr = reg_waddr;
    assign b1.reg_wdata = reg_wdata; assign b0.reg_wdata = reg_wdata;
    assign b1.ex_ready = ex_ready;   assign b0.ex_ready = ex_ready;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        wb;
        logic [1:0]  src;
        logic        mw, mr, jp, br, am, bm, il;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // inst, opcode, rd, imm, wb, src, mw, mr, jump, branch, A, B, illegal
        vecs[0]  = '{32'hFFF00093, 7'h13, 5'd1,  64'hFFFFFFFFFFFFFFFF, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h0020B423, 7'h23, 5'd8,  64'd8,                1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000000, 7'h00, 5'd0,  64'd0,                1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h123452B7, 7'h37, 5'd5,  64'h0000000012345000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'hFFDFF0EF, 7'h6F, 5'd1,  64'hFFFFFFFFFFFFFFFC, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h00208863, 7'h63, 5'd16, 64'd16,               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFF397, 7'h17, 5'd7,  64'hFFFFFFFFFFFFF000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h00008067, 7'h67, 5'd0,  64'd0,                1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h00318233, 7'h33, 5'd4,  64'd0,                1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000B183, 7'h03, 5'd3,  64'd0,                1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h8000809B, 7'h1B, 5'd1,  64'hFFFFFFFFFFFFF800, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h0000007F, 7'h7F, 5'd0,  64'd0,                1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; if_valid = 1'b0; flush = 1'b0; reg_wenable = 1'b0; ex_ready = 1'b0;
        inst_data = '0; pc_in = '0; reg_waddr = '0; reg_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset id_valid", b1.id_valid, 0);
        chk("reset immediate", b1.immediate, 0);
        chk("reset illegal", b1.illegal, 0);
        chk("reset opcode", b1.opcode, 0);
        chk("reset reg1_out", b1.reg1_out, 0);
        chk("reset wb_enable", b1.writeback_enable, 0);
        chk("reset if_ready", b1.if_ready, 1);

        // read of x5 after reset: add x6,x5,x5
        ex_ready = 1'b1; if_valid = 1'b1; inst_data = 32'h00528333; pc_in = 32'h10;
        tick();
        chk("x5 read reg1", b1.reg1_out, 0);
        chk("x5 read reg2", b1.reg2_out, 0);

        // decode table, back-to-back at one instruction per cycle
        for (int i = 0; i < 12; i++) begin
            inst_data = vecs[i].inst; pc_in = 32'h1000 + 32'(i * 4);
            #1 chk($sformatf("vec%0d if_ready", i), b1.if_ready, 1);
            tick();
            chk($sformatf("vec%0d id_valid", i), b1.id_valid, 1);
            chk($sformatf("vec%0d opcode", i), b1.opcode, vecs[i].opc);
            chk($sformatf("vec%0d reg_dest", i), b1.reg_dest, vecs[i].rd);
            chk($sformatf("vec%0d immediate", i), b1.immediate, vecs[i].imm);
            chk($sformatf("vec%0d pc_out", i), b1.pc_out, 32'h1000 + 32'(i * 4));
            chk($sformatf("vec%0d ctrl", i),
                {b1.writeback_enable, b1.writeback_source, b1.mem_wenable, b1.mem_renable,
                 b1.jump, b1.branch, b1.ALU_A_mux, b1.ALU_B_mux, b1.illegal},
                {vecs[i].wb, vecs[i].src, vecs[i].mw, vecs[i].mr,
                 vecs[i].jp, vecs[i].br, vecs[i].am, vecs[i].bm, vecs[i].il});
        end
        if_valid = 1'b0;
        tick();
        chk("drain id_valid", b1.id_valid, 0);

        // load-use: ld x3,0(x1) then add x4,x3,x3
        if_valid = 1'b1; inst_data = 32'h0000B183; pc_in = 32'h40;
        tick();
        inst_data = 32'h00318233; pc_in = 32'h44;
        #1 chk("hazard if_ready", b1.if_ready, 0);
        tick();
        chk("bubble id_valid", b1.id_valid, 0);
        chk("post-bubble if_ready", b1.if_ready, 1);
        tick();
        chk("stalled add id_valid", b1.id_valid, 1);
        chk("stalled add reg_dest", b1.reg_dest, 4);
        chk("stalled add pc", b1.pc_out, 32'h44);
        // ld then add x4,x0,x0 does not stall
        inst_data = 32'h0000B183; pc_in = 32'h48;
        tick();
        inst_data = 32'h00000233; pc_in = 32'h4C;
        #1 chk("no-hazard if_ready", b1.if_ready, 1);
        tick();
        chk("no-hazard pc", b1.pc_out, 32'h4C);
        if_valid = 1'b0;
        tick();

        // bypass into read path
        reg_wenable = 1'b1; reg_waddr = 5'd1; reg_wdata = 64'h1111;
        tick();
        reg_wdata = 64'h1234; if_valid = 1'b1; inst_data = 32'h00108133; pc_in = 32'h100;
        tick();
        chk("bypass reg1", b1.reg1_out, 64'h1234);
        chk("bypass reg2", b1.reg2_out, 64'h1234);
        chk("nobypass reg1", b0.reg1_out, 64'h1111);
        chk("nobypass reg2", b0.reg2_out, 64'h1111);
        // held operand update during stall
        ex_ready = 1'b0; if_valid = 1'b0; reg_wdata = 64'h5678;
        tick();
        chk("held bypass reg1", b1.reg1_out, 64'h5678);
        chk("held bypass reg2", b1.reg2_out, 64'h5678);
        chk("held nobypass reg1", b0.reg1_out, 64'h1111);
        reg_waddr = 5'd9; reg_wdata = 64'hDEAD;
        tick();
        chk("held unrelated wb", b1.reg1_out, 64'h5678);
        reg_wenable = 1'b0;

        // backpressure: held add stays while addi waits
        if_valid = 1'b1; inst_data = 32'hFFF00093; pc_in = 32'h200;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("bp%0d if_ready", c), b1.if_ready, 0);
            tick();
            chk($sformatf("bp%0d opcode", c), b1.opcode, 7'h33);
            chk($sformatf("bp%0d pc", c), b1.pc_out, 32'h100);
            chk($sformatf("bp%0d id_valid", c), b1.id_valid, 1);
        end
        ex_ready = 1'b1;
        #1 chk("bp release if_ready", b1.if_ready, 1);
        tick();
        chk("bp next opcode", b1.opcode, 7'h13);
        chk("bp next pc", b1.pc_out, 32'h200);
        inst_data = 32'h123452B7; pc_in = 32'h204;
        tick();
        chk("bp order pc", b1.pc_out, 32'h204);
        chk("x1 regfile after bypass", b0.reg1_out, 64'h0);

        // flush with a held and an incoming instruction
        ex_ready = 1'b0; inst_data = 32'h00108133; pc_in = 32'h300; flush = 1'b1;
        #1 chk("flush if_ready", b1.if_ready, 1);
        tick();
        chk("flush id_valid", b1.id_valid, 0);
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        tick();
        chk("post-flush id_valid", b1.id_valid, 0);

        // reset during a stall discards the held instruction
        ex_ready = 1'b0; if_valid = 1'b1; inst_data = 32'hFFF00093; pc_in = 32'h400;
        tick();
        chk("pre-reset held", b1.id_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid-stall reset id_valid", b1.id_valid, 0);
        chk("mid-stall reset immediate", b1.immediate, 0);
        reset = 1'b0; if_valid = 1'b0;
        tick();
        chk("after reset no bubble", b1.id_valid, 0);
        ex_ready = 1'b1; if_valid = 1'b1; inst_data = 32'h00108133; pc_in = 32'h500;
        tick();
        chk("rf cleared x1", b1.reg1_out, 0);
        if_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
